uart_tx_feeder: RTL
===================

Name: uart_tx_feeder

Overview:
Byte buffer and launch controller sitting directly upstream of the UART transmitter; it drives the transmitter's parallel byte input and start strobe.
- Host side pushes bytes into an internal circular FIFO.
- Feeder pops one byte at a time, holds it stable on tx_data, pulses tx_start, and waits for the transmitter's busy cycle to finish before launching the next.
- Decouples bursty host writes from the slow serial bit rate.

Parameters:
DATA_W, 8, byte width presented to transmitter.
DEPTH, 8, FIFO entries; power of two, >= 2.
ADDR_W, 3, log2(DEPTH); pointer width.
ACK_TIMEOUT, 64, clock cycles allowed for tx_busy to rise after tx_start before the launch is abandoned.

Ports:
clock  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
wr_en  input  1  host push request.
wr_data  input  DATA_W  host byte, sampled when wr_en high.
ovf_clr  input  1  clears sticky overflow flag.
tx_busy  input  1  from transmitter; high while a frame is on the line.
tx_data  output  DATA_W  byte to transmitter, registered.
tx_start  output  1  one-cycle launch strobe, registered.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  ADDR_W+1  entries currently stored, 0..DEPTH.
overflow  output  1  sticky: a push was dropped.
timeout  output  1  one-cycle pulse when a launch is abandoned.

Behaviour:
Reset values
- All outputs are 0, except empty = 1.
- wr_ptr, rd_ptr, count, and the state machine are cleared, and the state is IDLE.
- Reset is asynchronous: asserting it mid-frame drops tx_start and tx_data to 0 in the same instant.
- FIFO contents are lost on reset.

FIFO
- Push accepted iff wr_en && !full. Memory[wr_ptr] <= wr_data, and wr_ptr increments modulo DEPTH (natural wrap of ADDR_W bits).
- Push while full: byte is dropped, pointers unchanged, overflow <= 1.
- overflow stays set until ovf_clr or reset. If ovf_clr and a dropped push coincide, the set wins.
- Pop occurs only in the IDLE->LOAD transition: tx_data <= memory[rd_ptr], and rd_ptr increments.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A push into an empty FIFO is not visible to the launcher until the following cycle. Minimum write-to-tx_start latency is 3 cycles: push at cycle N; IDLE sees !empty at N+1; LOAD at N+2; tx_start high at N+3.
- full, empty, and count are combinational from the registered count.

State machine (registered)
- IDLE: if !empty, pop and go to LOAD; else stay.
- LOAD: tx_data now valid. Go to START.
- START: tx_start = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy = 1, then go to WAIT_DONE. If the counter reaches ACK_TIMEOUT first, pulse timeout for 1 cycle and go to IDLE; the byte is discarded, not re-queued.
- WAIT_DONE: wait for tx_busy = 0, then go to IDLE.
- tx_data holds its value from LOAD until the next LOAD, so it stays stable for the entire frame.
- tx_start never asserts in any state other than START.
- Back-to-back bytes: the gap between tx_busy falling and the next tx_start is 3 cycles (IDLE, LOAD, START).
- tx_busy already high on entering WAIT_ACK: advance to WAIT_DONE on the next cycle.
- tx_busy changes are synchronous to clock. No synchronizer is required; the transmitter shares this clock domain.

Test Plan:
- Reset then single push of 12 → tx_data = 12 and tx_start high exactly 1 cycle, 3 cycles after the push. Model tx_busy high for 10 cycles → no second tx_start; empty = 1 afterwards.
- Push 12, 45, 9, 67, 101 on consecutive cycles → count peaks at 4 or 5. tx_data emits 12, 45, 9, 67, 101 in order, each held stable across its busy window. Each tx_start follows the previous tx_busy fall by 3 cycles.
- Fill to DEPTH = 8 with busy held high, then push 0xAA → full = 1, overflow = 1, count = 8, 0xAA is never transmitted. ovf_clr → overflow = 0.
- Push 10 bytes 0..9 while draining → pointers wrap past 7 and output order is 0..9 exactly.
- Push 0x55 with tx_busy tied low → after ACK_TIMEOUT cycles in WAIT_ACK, timeout pulses once, state returns to IDLE, count = 0.
- Assert reset during WAIT_DONE with 3 bytes queued → tx_data = 0, tx_start = 0, count = 0, empty = 1 immediately. After release, no tx_start occurs until a new push.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte buffer and launch controller placed directly in front of a UART
// transmitter. The host pushes bytes into a circular FIFO. The launcher pops
// one byte at a time and presents it on tx_data. It then pulses tx_start and
// waits for the transmitter's busy window to close before it launches the
// next byte.
//
// Ports
//   clock     system clock, all state on the rising edge
//   reset     asynchronous, active-high; clears all state immediately
//   wr_en     host push request
//   wr_data   host byte, sampled when wr_en is high
//   ovf_clr   clears the sticky overflow flag
//   tx_busy   transmitter busy, synchronous to clock
//   tx_data   registered byte to the transmitter, stable for a whole frame
//   tx_start  registered one-cycle launch strobe
//   full      count == DEPTH
//   empty     count == 0
//   count     entries currently stored, 0..DEPTH
//   overflow  sticky: a push arrived while full and was dropped
//   timeout   one-cycle pulse when a launch saw no busy acknowledge
module uart_tx_feeder #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ovf_clr,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              timeout
);

  localparam int                TO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0]   ACK_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [TO_W-1:0]     ack_cnt;
  logic                push, pop, ack_expired;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  // Next-state logic. The pop happens only on the IDLE->LOAD transition.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    ack_expired = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:  state_next = START;
      START: state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          // The transmitter never acknowledged. The byte is abandoned.
          ack_expired = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control, pointers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ack_cnt  <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      // Registered from the next state, so the strobe lines up exactly with START.
      tx_start <= (state_next == START);
      timeout  <= ack_expired;
      // WAIT_ACK counts its own cycles. The count restarts in START.
      if (state == START)         ack_cnt <= '0;
      else if (state == WAIT_ACK) ack_cnt <= ack_cnt + TO_W'(1);
      // A dropped push outranks a simultaneous clear.
      if (wr_en && full)  overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
    end
  end

  // Storage. The contents are not reset; stale entries are never read
  // because the pointers and count are cleared.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule
